// File: rtl/csr_sequencer_if.sv
// Handshake and bus bundles around the CSR sequencer: execute-stage request,
// CSR file read/write port, and writeback response.

interface csr_req_if #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CSR_AW = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [CSR_AW-1:0] req_addr;
   logic [XLEN-1:0]   req_src;
   logic [XLEN-1:0]   req_pc;

   modport master (output req_valid, req_op, req_addr, req_src, req_pc, input req_ready);
   modport slave  (input req_valid, req_op, req_addr, req_src, req_pc, output req_ready);
endinterface

interface csr_port_if #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CSR_AW = 12
);
   logic [CSR_AW-1:0] csr_ra;
   logic [XLEN-1:0]   csr_rd;
   logic              csr_valid;
   logic [CSR_AW-1:0] csr_wa;
   logic [XLEN-1:0]   csr_wd;

   modport master (output csr_ra, csr_valid, csr_wa, csr_wd, input csr_rd);
   modport slave  (input csr_ra, csr_valid, csr_wa, csr_wd, output csr_rd);
endinterface

interface csr_resp_if #(
   parameter int unsigned XLEN = 64
);
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_data;
   logic            resp_redirect;
   logic [XLEN-1:0] resp_target;
   logic            resp_illegal;

   modport master (output resp_valid, resp_data, resp_redirect, resp_target, resp_illegal,
                   input resp_ready);
   modport slave  (input resp_valid, resp_data, resp_redirect, resp_target, resp_illegal,
                   output resp_ready);
endinterface

// File: rtl/csr_sequencer.sv
// CSR port initiator: runs one CSR instruction, ECALL entry or MRET at a time,
// splitting multi-register updates into back-to-back single writes.

module csr_sequencer #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CSR_AW = 12
) (
   input  logic       clk,
   input  logic       reset,
   csr_req_if.slave   req,
   csr_port_if.master csr,
   csr_resp_if.master resp
);

   localparam logic [2:0] OP_RW    = 3'd0;
   localparam logic [2:0] OP_RS    = 3'd1;
   localparam logic [2:0] OP_RC    = 3'd2;
   localparam logic [2:0] OP_ECALL = 3'd3;
   localparam logic [2:0] OP_MRET  = 3'd4;

   localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
   localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WRITE, S_TRAP_EPC, S_TRAP_CAUSE, S_TRAP_STATUS, S_MRET_STATUS, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q;
   logic [CSR_AW-1:0] addr_q;
   logic [XLEN-1:0]   src_q, pc_q, old_q, target_q;
   logic [XLEN-1:0]   status_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req.req_valid) state_d = (req.req_op <= OP_MRET) ? S_READ : S_RESP;
         end
         S_READ: begin
            case (op_q)
               OP_ECALL: state_d = S_TRAP_EPC;
               OP_MRET:  state_d = S_MRET_STATUS;
               OP_RW:    state_d = S_WRITE;
               default:  state_d = (src_q == '0) ? S_RESP : S_WRITE;
            endcase
         end
         S_WRITE:       state_d = S_RESP;
         S_TRAP_EPC:    state_d = S_TRAP_CAUSE;
         S_TRAP_CAUSE:  state_d = S_TRAP_STATUS;
         S_TRAP_STATUS: state_d = S_RESP;
         S_MRET_STATUS: state_d = S_RESP;
         S_RESP: begin
            if (resp.resp_ready) state_d = S_IDLE;
         end
         default:       state_d = S_IDLE;
      endcase
   end

   // Request latch; old value / redirect target captured in READ
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q     <= '0;
         addr_q   <= '0;
         src_q    <= '0;
         pc_q     <= '0;
         old_q    <= '0;
         target_q <= '0;
      end else if (state_q == S_IDLE && req.req_valid) begin
         op_q     <= req.req_op;
         addr_q   <= req.req_addr;
         src_q    <= req.req_src;
         pc_q     <= req.req_pc;
         old_q    <= '0;
         target_q <= '0;
      end else if (state_q == S_READ) begin
         if (op_q == OP_ECALL)     target_q <= {csr.csr_rd[XLEN-1:2], 2'b00};
         else if (op_q == OP_MRET) target_q <= csr.csr_rd;
         else                      old_q    <= csr.csr_rd;
      end
   end

   always_comb begin
      req.req_ready      = 1'b0;
      csr.csr_ra         = '0;
      csr.csr_valid      = 1'b0;
      csr.csr_wa         = '0;
      csr.csr_wd         = '0;
      resp.resp_valid    = 1'b0;
      resp.resp_data     = '0;
      resp.resp_redirect = 1'b0;
      resp.resp_target   = '0;
      resp.resp_illegal  = 1'b0;
      status_w           = csr.csr_rd;
      case (state_q)
         S_IDLE: req.req_ready = 1'b1;
         S_READ: begin
            case (op_q)
               OP_ECALL: csr.csr_ra = A_MTVEC;
               OP_MRET:  csr.csr_ra = A_MEPC;
               default:  csr.csr_ra = addr_q;
            endcase
         end
         S_WRITE: begin
            csr.csr_valid = 1'b1;
            csr.csr_wa    = addr_q;
            case (op_q)
               OP_RS:   csr.csr_wd = old_q | src_q;
               OP_RC:   csr.csr_wd = old_q & ~src_q;
               default: csr.csr_wd = src_q;
            endcase
         end
         S_TRAP_EPC: begin
            csr.csr_valid = 1'b1;
            csr.csr_wa    = A_MEPC;
            csr.csr_wd    = pc_q;
         end
         S_TRAP_CAUSE: begin
            csr.csr_valid = 1'b1;
            csr.csr_wa    = A_MCAUSE;
            csr.csr_wd    = XLEN'(4'd11);
         end
         // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
         S_TRAP_STATUS: begin
            csr.csr_ra      = A_MSTATUS;
            status_w[7]     = csr.csr_rd[3];
            status_w[3]     = 1'b0;
            status_w[12:11] = 2'b11;
            csr.csr_valid   = 1'b1;
            csr.csr_wa      = A_MSTATUS;
            csr.csr_wd      = status_w;
         end
         // Trap return: MIE <= MPIE, MPIE <= 1
         S_MRET_STATUS: begin
            csr.csr_ra      = A_MSTATUS;
            status_w[3]     = csr.csr_rd[7];
            status_w[7]     = 1'b1;
            status_w[12:11] = 2'b11;
            csr.csr_valid   = 1'b1;
            csr.csr_wa      = A_MSTATUS;
            csr.csr_wd      = status_w;
         end
         S_RESP: begin
            resp.resp_valid    = 1'b1;
            resp.resp_data     = old_q;
            resp.resp_redirect = (op_q == OP_ECALL) || (op_q == OP_MRET);
            resp.resp_target   = target_q;
            resp.resp_illegal  = (op_q > OP_MRET);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_csr_sequencer.sv
// Self-checking bench for csr_sequencer: a CSR file model on the port, and a
// transaction-level reference that predicts writes, read addresses and responses.

module tb_csr_sequencer;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned CSR_AW = 12;
   localparam logic [11:0] MSTATUS = 12'h300, MTVEC = 12'h305, MEPC = 12'h341, MCAUSE = 12'h342;

   typedef struct {
      int          k;
      logic [11:0] a;
      logic [63:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   csr_req_if  #(.XLEN(XLEN), .CSR_AW(CSR_AW)) req_if ();
   csr_port_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) csr_if ();
   csr_resp_if #(.XLEN(XLEN))                  resp_if ();

   csr_sequencer #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
      .clk(clk), .reset(reset), .req(req_if), .csr(csr_if), .resp(resp_if)
   );

   // CSR file seen by the DUT; preloads go through the same clocked writer
   logic [63:0] csr_file [0:4095];
   logic        file_clr, pre_en;
   logic [11:0] pre_addr;
   logic [63:0] pre_data;
   assign csr_if.csr_rd = csr_file[csr_if.csr_ra];

   always @(posedge clk) begin
      if (file_clr) begin
         for (int i = 0; i < 4096; i++) csr_file[i] <= '0;
      end else begin
         if (csr_if.csr_valid) csr_file[csr_if.csr_wa] <= csr_if.csr_wd;
         if (pre_en)           csr_file[pre_addr]      <= pre_data;
      end
   end

   logic [63:0] ref_csr [0:4095];
   wr_t         exp_w[$];
   int          exp_lat;
   logic [63:0] exp_data, exp_tgt;
   logic        exp_red, exp_ill;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference: what an instruction does to the CSR state and what it returns
   task automatic model(input logic [2:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic [63:0] pc);
      logic [63:0] old, nv, st;
      exp_w.delete();
      exp_data = '0; exp_tgt = '0; exp_red = 1'b0; exp_ill = 1'b0;
      case (op)
         3'd0, 3'd1, 3'd2: begin
            old      = ref_csr[addr];
            exp_data = old;
            if (op != 3'd0 && src == 64'd0) exp_lat = 2;
            else begin
               nv = (op == 3'd0) ? src : (op == 3'd1) ? (old | src) : (old & ~src);
               exp_w.push_back('{2, addr, nv});
               ref_csr[addr] = nv;
               exp_lat = 3;
            end
         end
         3'd3: begin
            exp_tgt = ref_csr[MTVEC] & ~64'd3;
            st = ref_csr[MSTATUS];
            nv = st; nv[7] = st[3]; nv[3] = 1'b0; nv[12:11] = 2'b11;
            exp_w.push_back('{2, MEPC, pc});
            exp_w.push_back('{3, MCAUSE, 64'd11});
            exp_w.push_back('{4, MSTATUS, nv});
            ref_csr[MEPC] = pc; ref_csr[MCAUSE] = 64'd11; ref_csr[MSTATUS] = nv;
            exp_red = 1'b1; exp_lat = 5;
         end
         3'd4: begin
            exp_tgt = ref_csr[MEPC];
            st = ref_csr[MSTATUS];
            nv = st; nv[3] = st[7]; nv[7] = 1'b1; nv[12:11] = 2'b11;
            exp_w.push_back('{2, MSTATUS, nv});
            ref_csr[MSTATUS] = nv;
            exp_red = 1'b1; exp_lat = 3;
         end
         default: begin
            exp_ill = 1'b1; exp_lat = 1;
         end
      endcase
   endtask

   function automatic logic [11:0] exp_ra(input logic [2:0] op, input logic [11:0] addr, input int k);
      if (k == 1) begin
         if (op <= 3'd2) return addr;
         if (op == 3'd3) return MTVEC;
         if (op == 3'd4) return MEPC;
      end
      if (op == 3'd3 && k == 4) return MSTATUS;
      if (op == 3'd4 && k == 2) return MSTATUS;
      return 12'h000;
   endfunction

   task automatic preload(input logic [11:0] a, input logic [63:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk);
      #1 pre_en = 1'b0;
      ref_csr[a] = d;
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic do_txn(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] src,
                         input logic [63:0] pc, input int rdy_dly, input bit noise, input string tag);
      wr_t obs_w[$];
      int k, hold;
      bit got, done;
      logic [63:0] f_data, f_tgt;
      logic f_red, f_ill;
      model(op, addr, src, pc);
      @(negedge clk);
      n_checks++;
      if (req_if.req_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s req_ready_idle: got %b expected 1", tag, req_if.req_ready);
      end
      req_if.req_valid = 1'b1; req_if.req_op = op; req_if.req_addr = addr;
      req_if.req_src = src; req_if.req_pc = pc;
      @(posedge clk); @(negedge clk);
      if (noise) begin
         req_if.req_op = 3'($urandom); req_if.req_addr = 12'($urandom);
         req_if.req_src = {$urandom, $urandom}; req_if.req_pc = {$urandom, $urandom};
      end else req_if.req_valid = 1'b0;
      k = 1; hold = 0; got = 0; done = 0;
      f_data = '0; f_tgt = '0; f_red = 1'b0; f_ill = 1'b0;
      while (!done && k <= 40) begin
         if (csr_if.csr_valid === 1'b1) obs_w.push_back('{k, csr_if.csr_wa, csr_if.csr_wd});
         else begin
            n_checks++;
            if (csr_if.csr_wa !== 12'h0 || csr_if.csr_wd !== 64'h0) begin
               n_fail++; $display("FAIL %s idle_write_bus k=%0d: got wa=%h wd=%h expected 0", tag, k, csr_if.csr_wa, csr_if.csr_wd);
            end
         end
         n_checks++;
         if (csr_if.csr_ra !== exp_ra(op, addr, k)) begin
            n_fail++; $display("FAIL %s csr_ra k=%0d: got %h expected %h", tag, k, csr_if.csr_ra, exp_ra(op, addr, k));
         end
         n_checks++;
         if (req_if.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s req_ready_busy k=%0d: got %b expected 0", tag, k, req_if.req_ready);
         end
         if (resp_if.resp_valid === 1'b1) begin
            if (!got) begin
               got = 1;
               f_data = resp_if.resp_data; f_tgt = resp_if.resp_target;
               f_red = resp_if.resp_redirect; f_ill = resp_if.resp_illegal;
               n_checks += 4;
               if (k != exp_lat) begin n_fail++; $display("FAIL %s resp_latency: got %0d expected %0d", tag, k, exp_lat); end
               if (f_data !== exp_data) begin n_fail++; $display("FAIL %s resp_data: got %h expected %h", tag, f_data, exp_data); end
               if (f_red !== exp_red) begin n_fail++; $display("FAIL %s resp_redirect: got %b expected %b", tag, f_red, exp_red); end
               if (f_ill !== exp_ill) begin n_fail++; $display("FAIL %s resp_illegal: got %b expected %b", tag, f_ill, exp_ill); end
               if (exp_red) begin
                  n_checks++;
                  if (f_tgt !== exp_tgt) begin n_fail++; $display("FAIL %s resp_target: got %h expected %h", tag, f_tgt, exp_tgt); end
               end
            end else begin
               n_checks++;
               if (resp_if.resp_data !== f_data || resp_if.resp_target !== f_tgt ||
                   resp_if.resp_redirect !== f_red || resp_if.resp_illegal !== f_ill) begin
                  n_fail++; $display("FAIL %s resp_stable k=%0d: got data=%h tgt=%h expected data=%h tgt=%h",
                                     tag, k, resp_if.resp_data, resp_if.resp_target, f_data, f_tgt);
               end
            end
            if (hold >= rdy_dly) begin
               req_if.req_valid = 1'b0; resp_if.resp_ready = 1'b1;
               @(posedge clk); @(negedge clk);
               resp_if.resp_ready = 1'b0;
               done = 1;
            end else hold++;
         end
         if (!done) begin @(posedge clk); @(negedge clk); k++; end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL %s resp_timeout: got no handshake expected resp by cycle %0d", tag, exp_lat);
         req_if.req_valid = 1'b0;
         pulse_reset();
      end else begin
         n_checks++;
         if (resp_if.resp_valid !== 1'b0 || req_if.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s back_to_idle: got resp_valid=%b req_ready=%b expected 0/1", tag, resp_if.resp_valid, req_if.req_ready);
         end
      end
      n_checks++;
      if (obs_w.size() != exp_w.size()) begin
         n_fail++; $display("FAIL %s write_count: got %0d expected %0d", tag, obs_w.size(), exp_w.size());
      end
      for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
         n_checks++;
         if (obs_w[i].k != exp_w[i].k || obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d) begin
            n_fail++; $display("FAIL %s write%0d: got k=%0d a=%h d=%h expected k=%0d a=%h d=%h", tag, i,
                               obs_w[i].k, obs_w[i].a, obs_w[i].d, exp_w[i].k, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (req_if.req_ready !== 1'b1 || csr_if.csr_valid !== 1'b0 || resp_if.resp_valid !== 1'b0 ||
          csr_if.csr_ra !== 12'h0 || csr_if.csr_wa !== 12'h0 || csr_if.csr_wd !== 64'h0 ||
          resp_if.resp_data !== 64'h0 || resp_if.resp_target !== 64'h0 ||
          resp_if.resp_redirect !== 1'b0 || resp_if.resp_illegal !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got ready=%b cv=%b rv=%b ra=%h wa=%h expected 1/0/0/0/0",
                            req_if.req_ready, csr_if.csr_valid, resp_if.resp_valid, csr_if.csr_ra, csr_if.csr_wa);
      end
      reset = 1'b1; file_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (req_if.req_ready !== 1'b1 || resp_if.resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle: got ready=%b rv=%b expected 1/0", req_if.req_ready, resp_if.resp_valid);
      end
   endtask

   task automatic test_csrrw();
      preload(12'h340, 64'h1234);
      do_txn(3'd0, 12'h340, 64'hDEAD, 64'h8000_0000, 0, 0, "csrrw");
      n_checks++;
      if (csr_file[12'h340] !== 64'hDEAD) begin
         n_fail++; $display("FAIL csrrw_mscratch: got %h expected dead", csr_file[12'h340]);
      end
   endtask

   task automatic test_rs_rc();
      preload(MSTATUS, 64'h0);
      do_txn(3'd1, MSTATUS, 64'h8, 64'h0, 0, 0, "csrrs");
      do_txn(3'd2, MSTATUS, 64'h0, 64'h0, 0, 0, "csrrc_zero");
      n_checks++;
      if (csr_file[MSTATUS] !== 64'h8) begin
         n_fail++; $display("FAIL rs_rc_mstatus: got %h expected 8", csr_file[MSTATUS]);
      end
   endtask

   task automatic test_ecall();
      preload(MTVEC, 64'h8000_0003);
      preload(MSTATUS, 64'h8);
      do_txn(3'd3, 12'h0, 64'h0, 64'h8000_0100, 0, 0, "ecall");
      n_checks++;
      if (csr_file[MSTATUS] !== 64'h1880 || csr_file[MEPC] !== 64'h8000_0100 || csr_file[MCAUSE] !== 64'd11) begin
         n_fail++; $display("FAIL ecall_state: got mstatus=%h mepc=%h mcause=%h expected 1880/80000100/b",
                            csr_file[MSTATUS], csr_file[MEPC], csr_file[MCAUSE]);
      end
   endtask

   task automatic test_mret();
      preload(MEPC, 64'h8000_0104);
      do_txn(3'd4, 12'h0, 64'h0, 64'h0, 0, 0, "mret");
      n_checks++;
      if (csr_file[MSTATUS] !== 64'h1888) begin
         n_fail++; $display("FAIL mret_mstatus: got %h expected 1888", csr_file[MSTATUS]);
      end
   endtask

   task automatic test_illegal();
      do_txn(3'd6, 12'h300, 64'hFF, 64'h0, 0, 0, "illegal6");
      do_txn(3'd7, 12'h305, 64'h1, 64'h0, 1, 0, "illegal7");
   endtask

   task automatic test_resp_stall();
      do_txn(3'd0, 12'h340, 64'h5555, 64'h0, 5, 0, "stall_rw");
      do_txn(3'd3, 12'h0, 64'h0, 64'h8000_0200, 5, 0, "stall_ecall");
   endtask

   task automatic test_reset_mid();
      logic [63:0] st0, mc0, pc;
      st0 = ref_csr[MSTATUS]; mc0 = 64'h77; pc = 64'h8000_0400;
      preload(MCAUSE, mc0);
      @(negedge clk);
      req_if.req_valid = 1'b1; req_if.req_op = 3'd3; req_if.req_pc = pc;
      @(posedge clk); @(negedge clk);
      req_if.req_valid = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      n_checks++;
      if (csr_if.csr_valid !== 1'b1 || csr_if.csr_wa !== MCAUSE) begin
         n_fail++; $display("FAIL mid_trap_cause: got cv=%b wa=%h expected 1/342", csr_if.csr_valid, csr_if.csr_wa);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (csr_if.csr_valid !== 1'b0 || req_if.req_ready !== 1'b1 || resp_if.resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_async: got cv=%b ready=%b rv=%b expected 0/1/0",
                            csr_if.csr_valid, req_if.req_ready, resp_if.resp_valid);
      end
      @(negedge clk); reset = 1'b1;
      ref_csr[MEPC] = pc;
      repeat (2) @(negedge clk);
      n_checks++;
      if (csr_file[MEPC] !== pc || csr_file[MCAUSE] !== mc0 || csr_file[MSTATUS] !== st0) begin
         n_fail++; $display("FAIL mid_reset_state: got mepc=%h mcause=%h mstatus=%h expected %h/%h/%h",
                            csr_file[MEPC], csr_file[MCAUSE], csr_file[MSTATUS], pc, mc0, st0);
      end
      n_checks++;
      if (req_if.req_ready !== 1'b1 || resp_if.resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_idle: got ready=%b rv=%b expected 1/0", req_if.req_ready, resp_if.resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] addrs [6];
      logic [2:0]  op;
      logic [11:0] a;
      logic [63:0] s;
      addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h000};
      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         a  = ($urandom_range(0, 5) == 5) ? 12'($urandom) : addrs[$urandom_range(0, 4)];
         s  = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
         do_txn(op, a, s, {$urandom, $urandom} & ~64'd3, $urandom_range(0, 3), 1'($urandom), "random");
      end
   endtask

   initial begin
      reset = 1'b0; file_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      req_if.req_valid = 1'b0; req_if.req_op = '0; req_if.req_addr = '0;
      req_if.req_src = '0; req_if.req_pc = '0; resp_if.resp_ready = 1'b0;
      for (int i = 0; i < 4096; i++) ref_csr[i] = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_csrrw();
      test_rs_rc();
      test_ecall();
      test_mret();
      test_illegal();
      test_resp_stall();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_sequencer.md
# csr_sequencer

Initiator side of the CSR port. Accepts one CSR instruction or trap/return request at a time from the execute stage, then sequences reads and single-register writes on the CSR file's read port (ra/rd) and write port (valid/wa/wd). Multi-register updates (ecall entry, mret) are split into back-to-back single writes. Returns the old CSR value and any PC redirect to writeback.

## Interface
- XLEN, 64, data width
- CSR_AW, 12, CSR address width
- clk  in  1  clock
- reset  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  0 RW, 1 RS, 2 RC, 3 ECALL, 4 MRET, 5-7 illegal
- req_addr  in  CSR_AW  target CSR; RW/RS/RC only
- req_src  in  XLEN  rs1 value or zero-extended uimm
- req_pc  in  XLEN  instruction PC
- csr_ra  out  CSR_AW  CSR read address
- csr_rd  in  XLEN  CSR read data, combinational from csr_ra
- csr_valid  out  1  write strobe, one cycle per write
- csr_wa  out  CSR_AW  write address
- csr_wd  out  XLEN  write data
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts
- resp_data  out  XLEN  old CSR value; 0 for ECALL/MRET/illegal
- resp_redirect  out  1  PC redirect required
- resp_target  out  XLEN  redirect PC
- resp_illegal  out  1  op was 5-7

## Operation
- CSR addresses: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
- States: IDLE, READ, WRITE, TRAP_EPC, TRAP_CAUSE, TRAP_STATUS, MRET_STATUS, RESP.
- IDLE: req_ready=1. On req_valid, latch op/addr/src/pc.
  - Ops 0-4 -> READ.
  - Ops 5-7 -> RESP with illegal=1.
- READ, RW/RS/RC: csr_ra=addr_q; old_q<=csr_rd.
  - RW -> WRITE.
  - RS/RC with src_q==0 -> RESP; no write issued.
  - RS/RC otherwise -> WRITE.
- WRITE: csr_valid=1, csr_wa=addr_q.
  - csr_wd = src_q (RW), old_q|src_q (RS), old_q&~src_q (RC).
  - Next state RESP.
- ECALL:
  - READ: csr_ra=MTVEC; target_q<={csr_rd[XLEN-1:2],2'b00}.
  - TRAP_EPC: write MEPC=pc_q.
  - TRAP_CAUSE: write MCAUSE=11.
  - TRAP_STATUS: csr_ra=MSTATUS; write csr_rd with bit7 (MPIE)=csr_rd[3], bit3 (MIE)=0, bits12:11 (MPP)=2'b11, all other bits unchanged.
  - Then RESP with redirect=1.
- MRET:
  - READ: csr_ra=MEPC; target_q<=csr_rd.
  - MRET_STATUS: csr_ra=MSTATUS; write bit3=csr_rd[7], bit7=1, bits12:11=2'b11.
  - Then RESP with redirect=1.
- Read-modify-write in one state is legal: csr_rd reflects pre-edge contents.
- RESP: resp_valid=1; outputs stable until resp_ready; on handshake -> IDLE.
- csr_ra=0 and csr_wa/csr_wd=0 in any state that does not use them.
- Unimplemented addresses need no special handling: the CSR file reads 0 and drops writes.

## Timing
- Request accepted at cycle T.
  - RW/RS/RC with write: READ T+1, WRITE T+2, resp_valid from T+3.
  - RS/RC with src 0: resp_valid from T+2.
  - ECALL: writes at T+2, T+3, T+4; resp_valid from T+5.
  - MRET: write at T+2; resp_valid from T+3.
  - Illegal: resp_valid from T+1.
- Writes commit in the CSR file at the rising edge ending the write cycle.
- Throughput: next request accepted the cycle after the resp handshake. No overlap between requests.
- Reset values: state IDLE, req_ready=1, csr_valid=0, resp_valid=0, all data/address outputs 0, latched registers 0.
- Reset asserted mid-sequence: state goes to IDLE immediately (async) and csr_valid drops the same cycle. Remaining writes are abandoned; no response is produced.
- resp_ready held low: stay in RESP indefinitely; no CSR activity.
- req_valid outside IDLE is ignored (req_ready=0).

## Test plan
- CSRRW 0x340, src 0xDEAD, mscratch 0x1234 -> one write of 0xDEAD at T+2; resp_data=0x1234 at T+3; redirect=0.
- CSRRS 0x300, src 0x8, mstatus 0x0 -> write 0x8. Then CSRRC 0x300, src 0 -> no csr_valid; resp_data=0x8 at T+2.
- ECALL, pc 0x80000100, mtvec 0x80000003, mstatus 0x8 -> writes MEPC=0x80000100, MCAUSE=11, MSTATUS=0x1880 on consecutive cycles; resp target 0x80000000, redirect=1.
- MRET, mepc 0x80000104, mstatus 0x1880 -> MSTATUS write 0x1888; resp target 0x80000104, redirect=1.
- req_op 6 -> resp_illegal=1 at T+1; no csr_valid ever asserted.
- Reset asserted during TRAP_CAUSE -> csr_valid low that cycle; MSTATUS never written; req_ready=1 after release. Also hold resp_ready low 5 cycles -> response stable throughout.
